// File: rtl/div_pkg.sv
// Shared types and constants for the LEGv8 integer divider.
// Provides the divider FSM state enum and the UDIV/SDIV decode fields.
`ifndef WORD
`define WORD 64
`endif

package div_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } div_state_t;

    // R-format opcode shared by UDIV and SDIV; shamt selects the variant.
    localparam logic [10:0] UDIV_OPCODE = 11'b10011010110;
    localparam logic [10:0] SDIV_OPCODE = 11'b10011010110;
    localparam logic [5:0]  UDIV_SHAMT  = 6'b000010;
    localparam logic [5:0]  SDIV_SHAMT  = 6'b000011;

endpackage

// File: rtl/div_step.sv
// Combinational single restoring-division step.
// Ports: rem_in/divisor/bit_in in, rem_out/q_bit out.
module div_step
    import div_pkg::*;
#(
    parameter int WIDTH = `WORD
) (
    input  logic [WIDTH-1:0] rem_in,
    input  logic [WIDTH-1:0] divisor,
    input  logic             bit_in,
    output logic [WIDTH-1:0] rem_out,
    output logic             q_bit
);

    // Shifted partial remainder needs one extra bit so the
    // comparison against the divisor never loses the carry-out.
    logic [WIDTH:0]   shifted;
    logic [WIDTH-1:0] diff;

    always_comb begin
        shifted = {rem_in, bit_in};
        q_bit   = (shifted >= {1'b0, divisor});
        // When the subtraction succeeds the true difference is below
        // the divisor, so the low WIDTH bits hold it exactly.
        diff    = shifted[WIDTH-1:0] - divisor;
        rem_out = q_bit ? diff : shifted[WIDTH-1:0];
    end

endmodule

// File: rtl/idiv_unit.sv
// Multi-cycle restoring integer divider (UDIV/SDIV), one bit per clock.
// Ports: clk, reset, start, is_signed, dividend, divisor in;
//        busy, done, quotient, remainder, div_by_zero out.
module idiv_unit
    import div_pkg::*;
#(
    parameter int WIDTH = `WORD
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    div_state_t state_q;
    div_state_t state_d;

    logic [CW-1:0]    cnt_q;
    logic [WIDTH-1:0] rem_q;
    logic [WIDTH-1:0] dd_q;
    logic [WIDTH-1:0] dvs_q;
    logic             q_neg_q;
    logic             r_neg_q;

    logic             accept;
    logic             zero_dvs;
    logic             last;
    logic             a_neg;
    logic             b_neg;
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;
    logic [WIDTH-1:0] step_rem;
    logic             step_q;
    logic [WIDTH-1:0] q_raw;

    always_comb begin
        accept   = start && (state_q == IDLE || state_q == DONE);
        zero_dvs = (divisor == '0);
        last     = (state_q == RUN) && (cnt_q == '0);
        a_neg    = is_signed && dividend[WIDTH-1];
        b_neg    = is_signed && divisor[WIDTH-1];
        // |MIN_INT| wraps to itself and is used as an unsigned magnitude.
        a_mag    = a_neg ? -dividend : dividend;
        b_mag    = b_neg ? -divisor : divisor;
        q_raw    = {dd_q[WIDTH-2:0], step_q};
    end

    // The dividend register shifts out its MSB each step and
    // shifts in the quotient bit, ending up holding the quotient.
    div_step #(
        .WIDTH(WIDTH)
    ) u_step (
        .rem_in (rem_q),
        .divisor(dvs_q),
        .bit_in (dd_q[WIDTH-1]),
        .rem_out(step_rem),
        .q_bit  (step_q)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = zero_dvs ? DONE : RUN;
                end
            end
            RUN: begin
                if (cnt_q == '0) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (start) begin
                    state_d = zero_dvs ? DONE : RUN;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy = (state_q == RUN);
        done = (state_q == DONE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q       <= '0;
            rem_q       <= '0;
            dd_q        <= '0;
            dvs_q       <= '0;
            q_neg_q     <= 1'b0;
            r_neg_q     <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else if (accept) begin
            cnt_q   <= CNT_LAST;
            rem_q   <= '0;
            dd_q    <= a_mag;
            dvs_q   <= b_mag;
            q_neg_q <= a_neg ^ b_neg;
            r_neg_q <= a_neg;
            // Zero divisor skips the iteration and gives the ARM result.
            if (zero_dvs) begin
                quotient    <= '0;
                remainder   <= dividend;
                div_by_zero <= 1'b1;
            end
        end else if (state_q == RUN) begin
            rem_q <= step_rem;
            dd_q  <= q_raw;
            if (last) begin
                quotient    <= q_neg_q ? -q_raw : q_raw;
                remainder   <= r_neg_q ? -step_rem : step_rem;
                div_by_zero <= 1'b0;
            end else begin
                cnt_q <= cnt_q - CW'(1);
            end
        end
    end

endmodule

// File: tb/tb_idiv_unit.sv
// Self-checking bench for idiv_unit against an arithmetic reference.
// Directed corner cases followed by randomized UDIV/SDIV operations.
module tb_idiv_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        is_signed;
    logic [63:0] dividend;
    logic [63:0] divisor;
    logic        busy;
    logic        done;
    logic [63:0] quotient;
    logic [63:0] remainder;
    logic        div_by_zero;

    int total  = 0;
    int passed = 0;
    int fails  = 0;

    localparam logic [63:0] MIN_INT = 64'h8000_0000_0000_0000;
    localparam logic [63:0] ONES    = 64'hFFFF_FFFF_FFFF_FFFF;

    idiv_unit #(
        .WIDTH(64)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .is_signed  (is_signed),
        .dividend   (dividend),
        .divisor    (divisor),
        .busy       (busy),
        .done       (done),
        .quotient   (quotient),
        .remainder  (remainder),
        .div_by_zero(div_by_zero)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference: plain arithmetic with the ARM zero and overflow rules.
    function automatic void model(input logic [63:0] a, input logic [63:0] b,
                                  input bit s, output logic [63:0] q,
                                  output logic [63:0] r, output bit dz);
        dz = 1'b0;
        if (b == 64'd0) begin
            q  = 64'd0;
            r  = a;
            dz = 1'b1;
        end else if (!s) begin
            q = a / b;
            r = a % b;
        end else if (a == MIN_INT && b == ONES) begin
            q = MIN_INT;
            r = 64'd0;
        end else begin
            q = $signed(a) / $signed(b);
            r = $signed(a) % $signed(b);
        end
    endfunction

    // Presents an op for one edge; returns #1 after the capture edge.
    task automatic launch(input logic [63:0] a, input logic [63:0] b,
                          input bit s);
        start     = 1'b1;
        is_signed = s;
        dividend  = a;
        divisor   = b;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Counts edges after capture until done, and busy samples on the way.
    task automatic wait_done(output int lat, output int bc);
        lat = 0;
        bc  = busy ? 1 : 0;
        while (!done && lat < 200) begin
            @(posedge clk);
            #1;
            lat++;
            if (busy) bc++;
        end
        check("done_seen", {63'd0, done}, 64'd1);
    endtask

    task automatic check_result(input string tag, input logic [63:0] a,
                                input logic [63:0] b, input bit s);
        logic [63:0] eq;
        logic [63:0] er;
        bit          ed;
        model(a, b, s, eq, er, ed);
        check({tag, "_quotient"}, quotient, eq);
        check({tag, "_remainder"}, remainder, er);
        check({tag, "_dbz"}, {63'd0, div_by_zero}, {63'd0, ed});
    endtask

    task automatic do_op(input string tag, input logic [63:0] a,
                         input logic [63:0] b, input bit s);
        int lat;
        int bc;
        bit zero;
        zero = (b == 64'd0);
        launch(a, b, s);
        wait_done(lat, bc);
        check_result(tag, a, b, s);
        check({tag, "_latency"}, 64'(lat), zero ? 64'd0 : 64'd64);
        check({tag, "_busy_cycles"}, 64'(bc), zero ? 64'd0 : 64'd64);
        @(posedge clk);
        #1;
        check({tag, "_done_pulse"}, {63'd0, done}, 64'd0);
    endtask

    initial begin
        int lat;
        int bc;
        int dcount;
        logic [63:0] ra;
        logic [63:0] rb;
        bit rs;

        reset     = 1'b1;
        start     = 1'b0;
        is_signed = 1'b0;
        dividend  = '0;
        divisor   = '0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;

        check("rst_busy", {63'd0, busy}, 64'd0);
        check("rst_done", {63'd0, done}, 64'd0);
        check("rst_quotient", quotient, 64'd0);
        check("rst_remainder", remainder, 64'd0);
        check("rst_dbz", {63'd0, div_by_zero}, 64'd0);

        do_op("udiv_100_7", 64'd100, 64'd7, 1'b0);
        check("udiv_100_7_lit_q", quotient, 64'd14);
        check("udiv_100_7_lit_r", remainder, 64'd2);
        do_op("sdiv_m100_7", -64'sd100, 64'd7, 1'b1);
        check("sdiv_m100_7_lit_q", quotient, -64'sd14);
        check("sdiv_m100_7_lit_r", remainder, -64'sd2);
        do_op("sdiv_100_m7", 64'd100, -64'sd7, 1'b1);
        check("sdiv_100_m7_lit_r", remainder, 64'd2);
        do_op("udiv_ones_0", ONES, 64'd0, 1'b0);
        check("udiv_ones_0_lit_r", remainder, ONES);
        do_op("sdiv_min_m1", MIN_INT, ONES, 1'b1);
        check("sdiv_min_m1_lit_q", quotient, MIN_INT);
        do_op("sdiv_7_0", 64'd7, 64'd0, 1'b1);

        // Back-to-back: second start lands in the DONE cycle.
        launch(64'd100, 64'd7, 1'b0);
        wait_done(lat, bc);
        check_result("b2b_first", 64'd100, 64'd7, 1'b0);
        launch(64'd50, 64'd5, 1'b0);
        check("b2b_busy", {63'd0, busy}, 64'd1);
        wait_done(lat, bc);
        check_result("b2b_second", 64'd50, 64'd5, 1'b0);
        check("b2b_second_lit_q", quotient, 64'd10);
        check("b2b_latency", 64'(lat), 64'd64);

        // Start pulse mid-RUN must not disturb the running op.
        launch(64'd1000, 64'd3, 1'b0);
        repeat (10) @(posedge clk);
        launch(64'd77, 64'd2, 1'b1);
        wait_done(lat, bc);
        check_result("midrun", 64'd1000, 64'd3, 1'b0);
        check("midrun_lit_q", quotient, 64'd333);
        check("midrun_latency", 64'(lat + 11), 64'd64);

        // Reset during RUN cycle 30 aborts without a done.
        launch(64'd100, 64'd7, 1'b0);
        repeat (29) @(posedge clk);
        #1;
        check("pre_rst_busy", {63'd0, busy}, 64'd1);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        check("abort_busy", {63'd0, busy}, 64'd0);
        check("abort_done", {63'd0, done}, 64'd0);
        check("abort_quotient", quotient, 64'd0);
        check("abort_remainder", remainder, 64'd0);
        check("abort_dbz", {63'd0, div_by_zero}, 64'd0);
        dcount = 0;
        repeat (80) begin
            @(posedge clk);
            #1;
            if (done || busy) dcount++;
        end
        check("abort_no_done", 64'(dcount), 64'd0);
        do_op("udiv_9_3", 64'd9, 64'd3, 1'b0);
        check("udiv_9_3_lit_q", quotient, 64'd3);

        for (int i = 0; i < 24; i++) begin
            ra = {$urandom, $urandom};
            rs = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 3))
                0: rb = 64'($urandom_range(1, 20));
                1: rb = {$urandom, $urandom};
                2: rb = ($urandom_range(0, 2) == 0) ? 64'd0 : 64'($urandom);
                default: rb = {32'd0, $urandom};
            endcase
            if (rs && $urandom_range(0, 1) == 1) rb = -rb;
            if (i % 5 == 0) ra = {32'd0, $urandom};
            do_op($sformatf("rand%0d", i), ra, rb, rs);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
